// File: rtl/mul8_seq_pkg.sv
// Shared types and constants for the 8x8 sequential multiply controller:
// FSM states, step count, per-step shift amounts and nibble selects.
package mul8_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic {
        NibLo = 1'b0,
        NibHi = 1'b1
    } nib_sel_e;

    localparam int unsigned NUM_STEPS = 4;
    localparam logic [1:0]  LAST_STEP = 2'(NUM_STEPS - 1);

    localparam logic [3:0] SHIFT_S0 = 4'd0;
    localparam logic [3:0] SHIFT_S1 = 4'd4;
    localparam logic [3:0] SHIFT_S2 = 4'd4;
    localparam logic [3:0] SHIFT_S3 = 4'd8;

    function automatic logic [3:0] step_shift(input logic [1:0] step);
        logic [3:0] sh;
        unique case (step)
            2'd0:    sh = SHIFT_S0;
            2'd1:    sh = SHIFT_S1;
            2'd2:    sh = SHIFT_S2;
            default: sh = SHIFT_S3;
        endcase
        return sh;
    endfunction

    // Step bit 1 picks the A nibble, bit 0 picks the B nibble.
    function automatic nib_sel_e a_nib_sel(input logic [1:0] step);
        return nib_sel_e'(step[1]);
    endfunction

    function automatic nib_sel_e b_nib_sel(input logic [1:0] step);
        return nib_sel_e'(step[0]);
    endfunction

endpackage

// File: rtl/wallace_mul.sv
// 4x4 unsigned multiplier: partial-product rows reduced by a carry-save
// stage, then a final ripple add.
module wallace_mul (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] prod_o
);

    logic [7:0] pp0, pp1, pp2, pp3;
    logic [7:0] s1, c1, s2, c2;

    always_comb begin
        pp0 = {4'b0, a_i & {4{b_i[0]}}};
        pp1 = {3'b0, a_i & {4{b_i[1]}}, 1'b0};
        pp2 = {2'b0, a_i & {4{b_i[2]}}, 2'b0};
        pp3 = {1'b0, a_i & {4{b_i[3]}}, 3'b0};
        // Two 3:2 compression layers, carries shifted into the next column.
        s1 = pp0 ^ pp1 ^ pp2;
        c1 = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;
        s2 = s1 ^ c1 ^ pp3;
        c2 = ((s1 & c1) | (s1 & pp3) | (c1 & pp3)) << 1;
        prod_o = s2 + c2;
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiply built from four 4x4 nibble products on one wallace_mul.
// Optional MUL8_ZERO_SKIP_EN: a zero operand skips straight to DONE.
module mul8_seq_ctrl
    import mul8_seq_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_product,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [15:0]      acc_q, acc_d;
    logic [7:0]       a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic       accept, zero_op;
    logic [1:0] sel_step;
    logic [3:0] mul_a, mul_b;
    logic [7:0] pp;

    assign accept = in_valid && (state_q == StIdle);

`ifdef MUL8_ZERO_SKIP_EN
    assign zero_op = (in_a == 8'd0) || (in_b == 8'd0);
`else
    assign zero_op = 1'b0;
`endif

    // Outside CALC the mux is parked on step 0 so the multiplier inputs stay defined.
    assign sel_step = (state_q == StCalc) ? step_q : 2'd0;
    assign mul_a    = (a_nib_sel(sel_step) == NibHi) ? a_q[7:4] : a_q[3:0];
    assign mul_b    = (b_nib_sel(sel_step) == NibHi) ? b_q[7:4] : b_q[3:0];

    wallace_mul u_wallace_mul (
        .a_i    (mul_a),
        .b_i    (mul_b),
        .prod_o (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = zero_op ? StDone : StCalc;
            StCalc: if (step_q == LAST_STEP) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == StIdle);
        busy        = (state_q != StIdle);
        out_valid   = (state_q == StDone);
        out_product = acc_q;
        out_tag     = tag_q;
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        tag_d  = tag_q;
        acc_d  = acc_q;
        step_d = step_q;
        if (accept) begin
            a_d    = in_a;
            b_d    = in_b;
            tag_d  = in_tag;
            acc_d  = 16'd0;
            step_d = 2'd0;
        end else if (state_q == StCalc) begin
            acc_d  = acc_q + ({8'd0, pp} << step_shift(step_q));
            step_d = step_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= 8'd0;
            b_q    <= 8'd0;
            tag_q  <= '0;
            acc_q  <= 16'd0;
            step_q <= 2'd0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            tag_q  <= tag_d;
            acc_q  <= acc_d;
            step_q <= step_d;
        end
    end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Self-checking bench for mul8_seq_ctrl: directed cases plus random traffic
// against a plain a*b reference with expected latency and initiation interval.
module tb_mul8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a, in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic [3:0]  out_tag;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int prev_accept;
    bit have_prev;

    mul8_seq_ctrl #(.TAG_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL8_ZERO_SKIP_EN
        if (a == 8'd0 || b == 8'd0) return 0;
`endif
        return 4;
    endfunction

    // One transaction; in_valid stays high throughout with junk operands after accept.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag,
                           input int hold);
        int lat;
        logic [15:0] exp_p;
        exp_p    = 16'(a) * 16'(b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        check("in_ready_before_accept", in_ready, 1);
        tick();
        if (have_prev) check("ii_min6", 32'(cyc - prev_accept >= 6), 1);
        prev_accept = cyc;
        have_prev   = 1'b1;
        in_a   = 8'($urandom);
        in_b   = 8'($urandom);
        in_tag = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("busy_calc", busy, 1);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        check("latency", lat, exp_latency(a, b));
        if (!out_valid) return;
        check("product", out_product, exp_p);
        check("tag", out_tag, tag);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_product", out_product, exp_p);
            check("hold_tag", out_tag, tag);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_done", in_ready, 1);
        check("valid_after_done", out_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_product"}, out_product, 0);
        check({tag, "_out_tag"}, out_tag, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        in_tag    = 4'd0;
        out_ready = 1'b0;
        have_prev = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        run_txn(8'h12, 8'h34, 4'h5, 0);
        run_txn(8'hFF, 8'hFF, 4'h1, 0);
        run_txn(8'h80, 8'h02, 4'h2, 0);
        run_txn(8'hA7, 8'h3C, 4'h9, 10);
        run_txn(8'h00, 8'h7F, 4'h3, 0);
        run_txn(8'h55, 8'h00, 4'h4, 1);

        // Reset during step 2: outputs return to reset values at once.
        in_valid = 1'b1;
        in_a     = 8'hEE;
        in_b     = 8'hDD;
        in_tag   = 4'hC;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick();
        rst_n     = 1'b1;
        have_prev = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("no_stale_valid", out_valid, 0);
            tick();
        end
        run_txn(8'h03, 8'h05, 4'h7, 0);

        for (int i = 0; i < 16; i++) begin
            run_txn(8'($urandom), 8'($urandom), 4'(i), $urandom_range(0, 3));
        end
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
